// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl: sequencing controller for a combinational three-rotor
// Enigma datapath. Accepts one plaintext letter per handshake and steps the
// rotors. It presents the letter and positions to the datapath, then returns
// the captured ciphertext letter over an output handshake.
//
// Build option: define ENIGMA_DBL_STEP_EN to reproduce the historical
// middle-rotor double step. Leave it undefined for pure odometer stepping.
module enigma_step_ctrl #(
  parameter logic [4:0] NOTCH_L = 5'd16,
  parameter logic [4:0] NOTCH_M = 5'd4,
  parameter logic [4:0] NOTCH_R = 5'd21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_load,
  input  logic [4:0]  cfg_pos_l,
  input  logic [4:0]  cfg_pos_m,
  input  logic [4:0]  cfg_pos_r,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_char,
  output logic [4:0]  pos_l,
  output logic [4:0]  pos_m,
  output logic [4:0]  pos_r,
  output logic [25:0] dp_in,
  input  logic [25:0] dp_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_char,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, STEP, EVAL, HOLD} state_t;

  state_t state, state_nxt;
  logic   at_notch_r, at_notch_m;
  logic   step_m, step_l;
  logic   bad_char;
  logic   dp_ok;
  logic [4:0] dp_idx;

  // The left rotor's turnover would only drive a fourth rotor, so it has no
  // effect here; it is kept so the rotor set parameters stay complete.
  logic unused_notch_l;
  assign unused_notch_l = ^NOTCH_L;

  // Start positions above 25 fold back once into 0..25.
  function automatic logic [4:0] wrap_pos(input logic [4:0] v);
    return (v > 5'd25) ? v - 5'd26 : v;
  endfunction

  // Advance one rotor position with wrap from 25 to 0.
  function automatic logic [4:0] inc_pos(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // Index of the highest set bit; only meaningful when the vector is one-hot.
  function automatic logic [4:0] onehot_idx(input logic [25:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  assign in_ready = (state == IDLE);
  assign bad_char = (in_char > 5'd25);
  assign dp_ok    = ($countones(dp_out) == 1);
  assign dp_idx   = onehot_idx(dp_out);

  // Stepping decision, evaluated on the positions held before the step.
  always_comb begin
    at_notch_r = (pos_r == NOTCH_R);
    at_notch_m = (pos_m == NOTCH_M);
`ifdef ENIGMA_DBL_STEP_EN
    step_m = at_notch_r | at_notch_m;
    step_l = at_notch_m;
`else
    step_m = at_notch_r;
    step_l = at_notch_r & at_notch_m;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = bad_char ? HOLD : STEP;
      STEP: state_nxt = EVAL;
      EVAL: state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rotor positions: loaded in IDLE, advanced once in STEP, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_l <= 5'd0;
      pos_m <= 5'd0;
      pos_r <= 5'd0;
    end else if (state == IDLE && cfg_load) begin
      pos_l <= wrap_pos(cfg_pos_l);
      pos_m <= wrap_pos(cfg_pos_m);
      pos_r <= wrap_pos(cfg_pos_r);
    end else if (state == STEP) begin
      pos_r <= inc_pos(pos_r);
      if (step_m) pos_m <= inc_pos(pos_m);
      if (step_l) pos_l <= inc_pos(pos_l);
    end
  end

  // Letter capture, result capture, output handshake and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_in     <= 26'd0;
      out_char  <= 5'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (bad_char) begin
              dp_in     <= 26'd0;
              out_char  <= 5'd0;
              out_valid <= 1'b1;
              err       <= 1'b1;
            end else begin
              dp_in <= 26'd1 << in_char;
            end
          end
        end
        EVAL: begin
          out_valid <= 1'b1;
          if (dp_ok) begin
            out_char <= dp_idx;
          end else begin
            out_char <= 5'd0;
            err      <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Bench for enigma_step_ctrl. Models the external datapath as rotors I/II/III
// with reflector B, and keeps its own rotor-position and cipher reference.
`timescale 1ns/1ps
module tb_enigma_step_ctrl;

  localparam int NM = 4;
  localparam int NR = 21;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_load = 1'b0;
  logic [4:0]  cfg_pos_l = '0, cfg_pos_m = '0, cfg_pos_r = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_char = '0;
  logic [4:0]  pos_l, pos_m, pos_r;
  logic [25:0] dp_in, dp_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_char;
  logic        err;
  bit          dp_kill = 1'b0;

  int checks = 0;
  int failures = 0;
  int m_l = 0, m_m = 0, m_r = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  enigma_step_ctrl dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_pos_l(cfg_pos_l), .cfg_pos_m(cfg_pos_m), .cfg_pos_r(cfg_pos_r),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
    .dp_in(dp_in), .dp_out(dp_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .err(err)
  );

  function automatic int rot(input string w, input int c, input int p, input bit inv);
    int x = (c + p) % 26;
    int y = 0;
    if (!inv) y = int'(w[x]) - 65;
    else for (int j = 0; j < 26; j++) if (int'(w[j]) - 65 == x) y = j;
    return (y - p + 26) % 26;
  endfunction

  function automatic int enc(input int c, input int pl, input int pm, input int pr);
    string w1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    string w2 = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    string w3 = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    string rb = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    int x = c;
    x = rot(w3, x, pr, 1'b0);
    x = rot(w2, x, pm, 1'b0);
    x = rot(w1, x, pl, 1'b0);
    x = int'(rb[x]) - 65;
    x = rot(w1, x, pl, 1'b1);
    x = rot(w2, x, pm, 1'b1);
    x = rot(w3, x, pr, 1'b1);
    return x;
  endfunction

  // External datapath: combinational rotor chain driven by the controller.
  always_comb begin
    dp_out = '0;
    if (!dp_kill && $countones(dp_in) == 1)
      for (int i = 0; i < 26; i++)
        if (dp_in[i]) dp_out[enc(i, int'(pos_l) % 26, int'(pos_m) % 26, int'(pos_r) % 26)] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_load(input int a, input int b, input int c);
    m_l = (a > 25) ? a - 26 : a;
    m_m = (b > 25) ? b - 26 : b;
    m_r = (c > 25) ? c - 26 : c;
  endtask

  task automatic model_step;
    bit at_r, at_m, adv_m, adv_l;
    at_r = (m_r == NR);
    at_m = (m_m == NM);
`ifdef ENIGMA_DBL_STEP_EN
    adv_m = at_r || at_m;
    adv_l = at_m;
`else
    adv_m = at_r;
    adv_l = at_r && at_m;
`endif
    m_r = (m_r + 1) % 26;
    if (adv_m) m_m = (m_m + 1) % 26;
    if (adv_l) m_l = (m_l + 1) % 26;
  endtask

  task automatic check_pos(input string tag);
    check({tag, ".pos_l"}, pos_l, m_l);
    check({tag, ".pos_m"}, pos_m, m_m);
    check({tag, ".pos_r"}, pos_r, m_r);
  endtask

  task automatic load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    cfg_load = 1'b1; cfg_pos_l = a; cfg_pos_m = b; cfg_pos_r = c;
    tick;
    cfg_load = 1'b0;
    model_load(a, b, c);
    check_pos("load");
  endtask

  // One letter through the controller; 'spam' drives cfg_load and in_valid
  // while the result is being held, which must have no effect.
  task automatic send(input logic [4:0] ch, input int hold, input bit ld,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                      input bit spam);
    int exp_c;
    check("idle.in_ready", in_ready, 1);
    in_valid = 1'b1; in_char = ch;
    if (ld) begin cfg_load = 1'b1; cfg_pos_l = a; cfg_pos_m = b; cfg_pos_r = c; end
    tick;
    in_valid = 1'b0; cfg_load = 1'b0;
    if (ld) model_load(a, b, c);
    model_step();
    exp_c = dp_kill ? 0 : enc(ch, m_l, m_m, m_r);
    if (dp_kill) m_err = 1'b1;
    check("step.in_ready", in_ready, 0);
    check("step.out_valid", out_valid, 0);
    tick;
    check_pos("eval");
    check("eval.in_ready", in_ready, 0);
    check("eval.out_valid", out_valid, 0);
    tick;
    check("hold.out_valid", out_valid, 1);
    check("hold.out_char", out_char, exp_c);
    check("hold.err", err, m_err);
    check("hold.in_ready", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      if (spam) begin
        cfg_load = 1'b1; in_valid = 1'b1; in_char = 5'($urandom_range(0, 25));
        cfg_pos_l = 5'($urandom_range(0, 31)); cfg_pos_m = 5'($urandom_range(0, 31));
        cfg_pos_r = 5'($urandom_range(0, 31));
      end
      tick;
      check("stall.out_valid", out_valid, 1);
      check("stall.out_char", out_char, exp_c);
      check("stall.in_ready", in_ready, 0);
      if (spam) check_pos("stall");
    end
    cfg_load = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("done.out_valid", out_valid, 0);
    check("done.in_ready", in_ready, 1);
    check_pos("done");
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    check("rst.out_valid", out_valid, 0);
    check("rst.out_char", out_char, 0);
    check("rst.err", err, 0);
    check("rst.dp_in", dp_in, 0);
    check("rst.in_ready", in_ready, 1);
    check_pos("rst");

    // First letter from zero positions
    send(5'd0, 0, 1'b0, '0, '0, '0, 1'b0);
    check("t1.pos_l", pos_l, 0);
    check("t1.pos_m", pos_m, 0);
    check("t1.pos_r", pos_r, 1);

    // Notch sequence from ADU
    load(5'd0, 5'd3, 5'd20);
    send(5'd7, 0, 1'b0, '0, '0, '0, 1'b0);
    check("adu1.pos_m", pos_m, 3);
    check("adu1.pos_r", pos_r, 21);
    send(5'd4, 0, 1'b0, '0, '0, '0, 1'b0);
    check("adu2.pos_m", pos_m, 4);
    check("adu2.pos_r", pos_r, 22);
    send(5'd11, 0, 1'b0, '0, '0, '0, 1'b0);
`ifdef ENIGMA_DBL_STEP_EN
    check("adu3.pos_l", pos_l, 1);
    check("adu3.pos_m", pos_m, 5);
`else
    check("adu3.pos_l", pos_l, 0);
    check("adu3.pos_m", pos_m, 4);
`endif
    check("adu3.pos_r", pos_r, 23);

    // Wrap at 25 and folding of oversize load values
    load(5'd25, 5'd25, 5'd25);
    send(5'd25, 0, 1'b0, '0, '0, '0, 1'b0);
    check("wrap.pos_r", pos_r, 0);
    check("wrap.pos_m", pos_m, 25);
    load(5'd1, 5'd2, 5'd30);
    check("fold.pos_r", pos_r, 4);

    // Load and letter in the same cycle: new positions are stepped
    send(5'd3, 0, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0);
    check("ldsame.pos_r", pos_r, 8);

    // Back-pressure: held result, ignored load and letter
    send(5'd19, 10, 1'b0, '0, '0, '0, 1'b1);

    // Randomized traffic against the reference
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0)
        load(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      send(5'($urandom_range(0, 25)), int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
    end

    // Broken datapath result
    dp_kill = 1'b1;
    send(5'd9, 0, 1'b0, '0, '0, '0, 1'b0);
    dp_kill = 1'b0;
    check("kill.err", err, 1);
    check("kill.out_char", out_char, 0);

    // Out-of-range letter goes straight to HOLD
    in_valid = 1'b1; in_char = 5'd27;
    tick;
    in_valid = 1'b0;
    check("bad.out_valid", out_valid, 1);
    check("bad.out_char", out_char, 0);
    check("bad.err", err, 1);
    check("bad.dp_in", dp_in, 0);
    check("bad.in_ready", in_ready, 0);
    check_pos("bad");
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bad.done", in_ready, 1);
    check("bad.out_valid_done", out_valid, 0);

    // Reset during STEP aborts the letter
    in_valid = 1'b1; in_char = 5'd5;
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_load(0, 0, 0);
    m_err = 1'b0;
    check("abort.out_valid", out_valid, 0);
    check("abort.err", err, 0);
    check("abort.in_ready", in_ready, 1);
    check_pos("abort");
    for (int k = 0; k < 4; k++) begin
      tick;
      check("abort.no_replay", out_valid, 0);
      check_pos("abort.idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
